// File: rtl/score_pair_sequencer.sv
// rtl/score_pair_sequencer.sv - captures class accumulators, saturates to 16-bit scores, streams them in pairs
module score_pair_sequencer #(
  parameter int NUM_CLASSES = 10,
  parameter int ACC_W       = 32,
  parameter int SHIFT       = 8,
  parameter int ADDR_W      = 4
) (
  input  logic              CLKEXT,
  input  logic              RST_COMP,
  input  logic              WR_EN,
  input  logic [ADDR_W-1:0] WR_ADDR,
  input  logic [ACC_W-1:0]  WR_DATA,
  input  logic              START,
  output logic              BUSY,
  output logic              DONE,
  output logic              EN_COMP,
  output logic              TRIG,
  output logic [15:0]       IN1,
  output logic [15:0]       IN2,
  output logic              SAT_FLAG,
  output logic              WR_ERR
);

  localparam int NUM_PAIRS = (NUM_CLASSES + 1) / 2;
  localparam int CNT_W     = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1;
  // Extended width guarantees the +/-32768 bounds are representable.
  localparam int EXT_W     = (ACC_W > 17) ? ACC_W : 17;

  localparam logic signed [EXT_W-1:0] SAT_MAX  = EXT_W'(32767);
  localparam logic signed [EXT_W-1:0] SAT_MIN  = EXT_W'(-32768);
  localparam logic [ADDR_W:0]         ADDR_LIM = (ADDR_W + 1)'(NUM_CLASSES);
  localparam logic [CNT_W-1:0]        LAST_PAIR = CNT_W'(NUM_PAIRS - 1);
  localparam logic [15:0]             NEG_FULL = 16'h8000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    ISSUE  = 2'd2,
    FINISH = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] pair_cnt_q, pair_cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             en_comp_q, en_comp_d;
  logic             trig_q, trig_d;
  logic [15:0]      in1_q, in1_d;
  logic [15:0]      in2_q, in2_d;
  logic             sat_flag_q, sat_flag_d;
  logic             wr_err_q, wr_err_d;

  logic [15:0] buf_q [NUM_CLASSES];
  logic [15:0] buf_d [NUM_CLASSES];

  // Buffer padded to an even length so the odd tail pairs with the most negative score.
  logic [15:0] pad [2*NUM_PAIRS];

  logic signed [ACC_W-1:0] wr_shift;
  logic signed [EXT_W-1:0] wr_ext;
  logic [15:0]             wr_score;
  logic                    wr_sat;
  logic                    wr_addr_ok;
  logic                    wr_accept;
  logic                    wr_drop;
  logic                    start_accept;
  logic [15:0]             pair_in1;
  logic [15:0]             pair_in2;

  for (genvar g = 0; g < 2*NUM_PAIRS; g++) begin : g_pad
    if (g < NUM_CLASSES) begin : g_real
      assign pad[g] = buf_q[g];
    end else begin : g_fill
      assign pad[g] = NEG_FULL;
    end
  end

  // Scale the incoming accumulator and clamp it into the signed 16-bit score range.
  always_comb begin
    wr_shift = $signed(WR_DATA) >>> SHIFT;
    wr_ext   = EXT_W'(wr_shift);
    wr_score = wr_ext[15:0];
    wr_sat   = 1'b0;
    if (wr_ext > SAT_MAX) begin
      wr_score = 16'h7FFF;
      wr_sat   = 1'b1;
    end else if (wr_ext < SAT_MIN) begin
      wr_score = NEG_FULL;
      wr_sat   = 1'b1;
    end
  end

  assign wr_addr_ok   = {1'b0, WR_ADDR} < ADDR_LIM;
  assign wr_accept    = WR_EN && (state_q == IDLE) && wr_addr_ok;
  assign wr_drop      = WR_EN && !wr_accept;
  assign start_accept = START && (state_q == IDLE);

  // Update the addressed buffer entry on an accepted write.
  always_comb begin
    for (int i = 0; i < NUM_CLASSES; i++) begin
      buf_d[i] = buf_q[i];
      if (wr_accept && (WR_ADDR == ADDR_W'(i))) begin
        buf_d[i] = wr_score;
      end
    end
  end

  // Select the even/odd score pair addressed by the pair counter.
  always_comb begin
    pair_in1 = NEG_FULL;
    pair_in2 = NEG_FULL;
    for (int k = 0; k < NUM_PAIRS; k++) begin
      if (pair_cnt_q == CNT_W'(k)) begin
        pair_in1 = pad[2*k];
        pair_in2 = pad[2*k+1];
      end
    end
  end

  // Sticky flags clear on an accepted START, but a same-edge set takes priority.
  always_comb begin
    sat_flag_d = sat_flag_q;
    wr_err_d   = wr_err_q;
    if (start_accept) begin
      sat_flag_d = 1'b0;
      wr_err_d   = 1'b0;
    end
    if (wr_accept && wr_sat) begin
      sat_flag_d = 1'b1;
    end
    if (wr_drop) begin
      wr_err_d = 1'b1;
    end
  end

  // Sequencer: FETCH latches a pair and strobes TRIG, ISSUE spaces strobes, FINISH pulses DONE.
  always_comb begin
    state_d    = state_q;
    pair_cnt_d = pair_cnt_q;
    busy_d     = busy_q;
    en_comp_d  = en_comp_q;
    done_d     = 1'b0;
    trig_d     = 1'b0;
    in1_d      = in1_q;
    in2_d      = in2_q;
    case (state_q)
      IDLE: begin
        if (START) begin
          state_d    = FETCH;
          pair_cnt_d = '0;
          busy_d     = 1'b1;
          en_comp_d  = 1'b1;
        end
      end
      FETCH: begin
        in1_d   = pair_in1;
        in2_d   = pair_in2;
        trig_d  = 1'b1;
        state_d = ISSUE;
      end
      ISSUE: begin
        if (pair_cnt_q == LAST_PAIR) begin
          state_d   = FINISH;
          busy_d    = 1'b0;
          en_comp_d = 1'b0;
          done_d    = 1'b1;
        end else begin
          pair_cnt_d = pair_cnt_q + CNT_W'(1);
          state_d    = FETCH;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d   = IDLE;
        busy_d    = 1'b0;
        en_comp_d = 1'b0;
      end
    endcase
  end

  // Control, output and flag registers.
  always_ff @(posedge CLKEXT or posedge RST_COMP) begin
    if (RST_COMP) begin
      state_q    <= IDLE;
      pair_cnt_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      en_comp_q  <= 1'b0;
      trig_q     <= 1'b0;
      in1_q      <= NEG_FULL;
      in2_q      <= NEG_FULL;
      sat_flag_q <= 1'b0;
      wr_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pair_cnt_q <= pair_cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      en_comp_q  <= en_comp_d;
      trig_q     <= trig_d;
      in1_q      <= in1_d;
      in2_q      <= in2_d;
      sat_flag_q <= sat_flag_d;
      wr_err_q   <= wr_err_d;
    end
  end

  // Score buffer registers.
  always_ff @(posedge CLKEXT or posedge RST_COMP) begin
    if (RST_COMP) begin
      for (int i = 0; i < NUM_CLASSES; i++) begin
        buf_q[i] <= NEG_FULL;
      end
    end else begin
      for (int i = 0; i < NUM_CLASSES; i++) begin
        buf_q[i] <= buf_d[i];
      end
    end
  end

  assign BUSY     = busy_q;
  assign DONE     = done_q;
  assign EN_COMP  = en_comp_q;
  assign TRIG     = trig_q;
  assign IN1      = in1_q;
  assign IN2      = in2_q;
  assign SAT_FLAG = sat_flag_q;
  assign WR_ERR   = wr_err_q;

endmodule

// File: tb/tb_score_pair_sequencer.sv
// tb/tb_score_pair_sequencer.sv - directed self-checking bench for score_pair_sequencer
module tb_score_pair_sequencer;

  localparam int P10 = 5;

  logic        CLKEXT = 1'b0;
  logic        RST_COMP;

  logic        WR_EN;
  logic [3:0]  WR_ADDR;
  logic [31:0] WR_DATA;
  logic        START;
  logic        BUSY, DONE, EN_COMP, TRIG, SAT_FLAG, WR_ERR;
  logic [15:0] IN1, IN2;

  logic        f_wr_en;
  logic [3:0]  f_wr_addr;
  logic [31:0] f_wr_data;
  logic        f_start;
  logic        f_busy, f_done, f_en_comp, f_trig, f_sat_flag, f_wr_err;
  logic [15:0] f_in1, f_in2;

  int errors = 0;
  int checks = 0;

  logic [15:0]        exp_sc [10];
  logic signed [15:0] max_seen;

  score_pair_sequencer #(.NUM_CLASSES(10), .ACC_W(32), .SHIFT(8), .ADDR_W(4)) u_dut (
    .CLKEXT(CLKEXT), .RST_COMP(RST_COMP),
    .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA), .START(START),
    .BUSY(BUSY), .DONE(DONE), .EN_COMP(EN_COMP), .TRIG(TRIG),
    .IN1(IN1), .IN2(IN2), .SAT_FLAG(SAT_FLAG), .WR_ERR(WR_ERR)
  );

  score_pair_sequencer #(.NUM_CLASSES(5), .ACC_W(32), .SHIFT(8), .ADDR_W(4)) u_dut5 (
    .CLKEXT(CLKEXT), .RST_COMP(RST_COMP),
    .WR_EN(f_wr_en), .WR_ADDR(f_wr_addr), .WR_DATA(f_wr_data), .START(f_start),
    .BUSY(f_busy), .DONE(f_done), .EN_COMP(f_en_comp), .TRIG(f_trig),
    .IN1(f_in1), .IN2(f_in2), .SAT_FLAG(f_sat_flag), .WR_ERR(f_wr_err)
  );

  always #5 CLKEXT = ~CLKEXT;

  task automatic tick();
    @(posedge CLKEXT);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full N=10 sequence against exp_sc; inject bits: 0 START mid-run, 1 write mid-run,
  // 2 START during the DONE cycle, 3 write class 0 on the START edge.
  task automatic run10(input int inject);
    int k;
    logic exp_trig;
    max_seen = 16'sh8000;
    START = 1'b1;
    if (inject[3]) begin
      WR_EN = 1'b1; WR_ADDR = 4'd0; WR_DATA = 32'd7 << 8;
    end
    tick();
    START = 1'b0; WR_EN = 1'b0;
    check("busy_e0", BUSY, 1);
    check("en_comp_e0", EN_COMP, 1);
    check("trig_e0", TRIG, 0);
    check("sat_clr_e0", SAT_FLAG, 0);
    check("err_clr_e0", WR_ERR, 0);
    for (int j = 1; j <= 2*P10+1; j++) begin
      if (inject[0] && j == 3) START = 1'b1;
      if (inject[1] && j == 4) begin
        WR_EN = 1'b1; WR_ADDR = 4'd2; WR_DATA = 32'd12345 << 8;
      end
      if (inject[2] && j == 2*P10+1) START = 1'b1;
      tick();
      START = 1'b0; WR_EN = 1'b0;
      exp_trig = (j % 2 == 1) && (j <= 2*P10-1);
      check($sformatf("trig_e%0d", j), TRIG, exp_trig);
      check($sformatf("done_e%0d", j), DONE, j == 2*P10);
      check($sformatf("busy_e%0d", j), BUSY, j < 2*P10);
      check($sformatf("en_comp_e%0d", j), EN_COMP, j < 2*P10);
      if (exp_trig) begin
        k = (j - 1) / 2;
        check($sformatf("in1_pair%0d", k), IN1, exp_sc[2*k]);
        check($sformatf("in2_pair%0d", k), IN2, exp_sc[2*k+1]);
        if ($signed(IN1) > max_seen) max_seen = $signed(IN1);
        if ($signed(IN2) > max_seen) max_seen = $signed(IN2);
      end
      if (inject[1] && j == 4) check("wr_err_busy", WR_ERR, 1);
    end
    tick();
    check("busy_idle", BUSY, 0);
    check("done_idle", DONE, 0);
    check("trig_idle", TRIG, 0);
  endtask

  initial begin
    RST_COMP = 1'b1;
    WR_EN = 1'b0; WR_ADDR = '0; WR_DATA = '0; START = 1'b0;
    f_wr_en = 1'b0; f_wr_addr = '0; f_wr_data = '0; f_start = 1'b0;
    tick();
    tick();
    check("rst_busy", BUSY, 0);
    check("rst_done", DONE, 0);
    check("rst_en_comp", EN_COMP, 0);
    check("rst_trig", TRIG, 0);
    check("rst_in1", IN1, 16'h8000);
    check("rst_in2", IN2, 16'h8000);
    check("rst_sat", SAT_FLAG, 0);
    check("rst_err", WR_ERR, 0);
    RST_COMP = 1'b0;
    tick();

    // Odd class count: scores 1..5, last pair padded.
    for (int c = 0; c < 5; c++) begin
      f_wr_en = 1'b1; f_wr_addr = 4'(c); f_wr_data = 32'(c + 1) << 8;
      tick();
    end
    f_wr_en = 1'b0;
    f_start = 1'b1;
    tick();
    f_start = 1'b0;
    for (int j = 1; j <= 7; j++) begin
      tick();
      check($sformatf("n5_trig_e%0d", j), f_trig, (j == 1) || (j == 3) || (j == 5));
      check($sformatf("n5_done_e%0d", j), f_done, j == 6);
      if (j == 1) begin check("n5_in1_p0", f_in1, 16'd1); check("n5_in2_p0", f_in2, 16'd2); end
      if (j == 3) begin check("n5_in1_p1", f_in1, 16'd3); check("n5_in2_p1", f_in2, 16'd4); end
      if (j == 5) begin check("n5_in1_p2", f_in1, 16'd5); check("n5_in2_p2", f_in2, 16'h8000); end
    end

    // Classes 0..9 with (c*100)<<8.
    for (int c = 0; c < 10; c++) begin
      WR_EN = 1'b1; WR_ADDR = 4'(c); WR_DATA = 32'(c * 100) << 8;
      exp_sc[c] = 16'(c * 100);
      tick();
    end
    WR_EN = 1'b0;
    run10(0);
    check("largest", 32'(max_seen), 32'd900);

    // Saturation both ways.
    WR_EN = 1'b1; WR_ADDR = 4'd3; WR_DATA = 32'h7FFF_FFFF;
    tick();
    WR_ADDR = 4'd4; WR_DATA = 32'h8000_0000;
    tick();
    WR_EN = 1'b0;
    check("sat_set", SAT_FLAG, 1);
    check("sat_no_err", WR_ERR, 0);
    exp_sc[3] = 16'h7FFF;
    exp_sc[4] = 16'h8000;
    run10(0);

    // Out-of-range address, then busy write, START while busy and START in the DONE cycle.
    WR_EN = 1'b1; WR_ADDR = 4'd12; WR_DATA = 32'd1 << 8;
    tick();
    WR_EN = 1'b0;
    check("err_addr", WR_ERR, 1);
    run10(7);
    check("err_sticky", WR_ERR, 1);
    run10(0);

    // Asynchronous reset after the second TRIG.
    START = 1'b1;
    tick();
    START = 1'b0;
    tick();
    tick();
    tick();
    check("mid_trig2", TRIG, 1);
    #2;
    RST_COMP = 1'b1;
    #1;
    check("mid_rst_trig", TRIG, 0);
    check("mid_rst_busy", BUSY, 0);
    check("mid_rst_en_comp", EN_COMP, 0);
    check("mid_rst_in1", IN1, 16'h8000);
    tick();
    RST_COMP = 1'b0;
    for (int j = 0; j < 4; j++) begin
      tick();
      check($sformatf("mid_no_done%0d", j), DONE, 0);
      check($sformatf("mid_no_busy%0d", j), BUSY, 0);
    end
    for (int c = 0; c < 10; c++) exp_sc[c] = 16'h8000;
    run10(0);

    // Write on the START edge is used by the first pair.
    exp_sc[0] = 16'd7;
    run10(8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
